serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  [0:WIDTH-1]  minuend; index 0 = LSB.
REQ-006 B  input  [0:WIDTH-1]  subtrahend; index 0 = LSB.
REQ-007 Diff  output  [0:WIDTH-1]  registered result A-B mod 2^WIDTH; index 0 = LSB.
REQ-008 Bout  output  1  registered final borrow; 1 when unsigned A < B.
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse; Diff/Bout valid from this cycle.
REQ-011 Ovf  output  1  signed overflow flag; present only per REQ-030.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; one-hot or binary encoding is free.
REQ-013 IDLE with start=1: capture A and B into shift registers, clear borrow and bit counter, go to SHIFT.
REQ-014 IDLE with start=0: remain in IDLE; Diff/Bout hold their values.
REQ-015 SHIFT: each cycle processes exactly one bit, LSB first, via the 1-bit full subtractor: d = a^b^bin, bout = (~a&b)|(~(a^b)&bin).
REQ-016 SHIFT: after the WIDTH-th bit, go to DONE; there are exactly WIDTH cycles in SHIFT.
REQ-017 DONE: load Diff and Bout, assert done for exactly one cycle, return to IDLE next cycle.
REQ-018 Latency: done is high in the cycle WIDTH+1 clocks after the edge that sampled start.
REQ-019 start is ignored in SHIFT and DONE; the operation in flight is not disturbed or restarted.
REQ-020 A/B may change after the capture edge without affecting the result.
REQ-021 Diff, Bout and Ovf hold until the next DONE; they do not update mid-operation.
REQ-022 Back-to-back: start high in the IDLE cycle after DONE is accepted; peak throughput is one result per WIDTH+2 cycles.
REQ-023 Arithmetic: Diff = (A - B) mod 2^WIDTH; Bout = (A < B) unsigned.
REQ-024 Boundaries: A=B gives Diff=0, Bout=0; A=0 with B=2^WIDTH-1 gives Diff=1, Bout=1.

Reset
REQ-025 rst=1 forces IDLE, busy=0, done=0, Diff=0, Bout=0, Ovf=0, and clears counter, borrow and shift registers on that edge.
REQ-026 rst has priority over start and over every FSM transition.
REQ-027 rst asserted mid-SHIFT aborts the operation; no done pulse follows, and Diff/Bout read 0.
REQ-028 The first start is accepted on the first edge with rst=0.

Configuration
REQ-029 The macro SERIAL_SUB_OVERFLOW_EN selects the overflow feature.
REQ-030 SERIAL_SUB_OVERFLOW_EN defined: Ovf port present; updated in DONE to (A[MSB]^B[MSB]) & (A[MSB]^Diff[MSB]) on the captured operands.
REQ-031 SERIAL_SUB_OVERFLOW_EN undefined: Ovf port and its logic absent; all other behaviour identical.

Structure
REQ-032 Shared package holds the FSM state typedef/localparams, the default WIDTH constant, and the counter width derived as clog2(WIDTH+1).
REQ-033 One sub-module, FullSubtractor1Bit, is instantiated once and reused every SHIFT cycle; ports A, B, Bin, Diff, Bout, purely combinational.

Verification (WIDTH=4)
REQ-034 A=9, B=3, start pulse -> done at +5 cycles; Diff=6, Bout=0; busy high for exactly 4 cycles.
REQ-035 A=3, B=9 -> Diff=10, Bout=1; with the macro defined, A=7, B=8 -> Diff=15, Bout=1, Ovf=1.
REQ-036 A=15, B=15, then A=0, B=15 back-to-back -> Diff=0, Bout=0, then Diff=1, Bout=1; exactly two done pulses.
REQ-037 start held high for 10 cycles with A=5, B=2 -> exactly one operation completes before re-accept; each done reports Diff=3.
REQ-038 rst pulsed on the 2nd SHIFT cycle -> no done pulse; all outputs 0; a new start with A=8, B=1 -> Diff=7.
REQ-039 A and B changed every cycle during SHIFT -> result equals the captured operands.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state type,
//   default operand width and the bit-counter width rule.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_fullsubtractor1bit.sv
// FullSubtractor1Bit
//   Purely combinational 1-bit full subtractor.
//   Ports:
//     A, B  : minuend / subtrahend bit
//     Bin   : borrow in
//     Diff  : difference bit
//     Bout  : borrow out
module FullSubtractor1Bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: Diff = (A - B) mod 2^WIDTH, one bit per
//   clock, LSB first, through a single shared full-subtractor cell.
//   Optional signed overflow output enabled by macro SERIAL_SUB_OVERFLOW_EN.
//   Ports:
//     clk    : clock, rising edge
//     rst    : synchronous active-high reset
//     start  : request, sampled only in IDLE
//     A, B   : operands, index 0 = LSB
//     Diff   : registered result, index 0 = LSB
//     Bout   : registered final borrow (A < B unsigned)
//     busy   : high while shifting
//     done   : one-cycle pulse, results valid from this cycle
//     Ovf    : signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start; results hold
//   ST_SHIFT | one operand bit processed per cycle
//   ST_DONE  | results loaded, done pulse issued next cycle
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  output logic [0:WIDTH-1] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               done_q, done_d;
  logic               fs_diff, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  FullSubtractor1Bit u_fs (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Bin  (borrow_q),
    .Diff (fs_diff),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    done_d    = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Port index 0 is the LSB; shift registers keep it at bit 0.
          for (int i = 0; i < WIDTH; i++) begin
            a_sr_d[i] = A[i];
            b_sr_d[i] = B[i];
          end
          diff_sr_d = '0;
          borrow_d  = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d   = A[WIDTH-1];
          b_msb_d   = B[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        // Result bits enter at the top so the LSB ends at bit 0 after WIDTH shifts.
        diff_sr_d = {fs_diff, diff_sr_q[WIDTH-1:1]};
        borrow_d  = fs_bout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        diff_d  = diff_sr_q;
        bout_d  = borrow_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_sr_q[WIDTH-1]);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      done_q    <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    Diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      Diff[i] = diff_q[i];
    end
  end

  assign Bout = bout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign Ovf  = ovf_q;
`endif

endmodule
